// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin arbiter sharing one single-port RAM between two requesters
module ram_rr_arbiter #(
  parameter int addr_width = 2,
  parameter int data_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] din0,
  output logic                  ack0,
  output logic [data_width-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] din1,
  output logic                  ack1,
  output logic [data_width-1:0] rdata1,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  output logic                  busy,
  output logic                  gnt_id
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  state_t state, state_next;
  logic winner, serve, sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_din;
  // on a tie the requester that was not served last wins
  assign winner   = (req0 && req1) ? ~gnt_id : req1;
  assign sel_we   = gnt_id ? we1 : we0;
  assign sel_addr = gnt_id ? addr1 : addr0;
  assign sel_din  = gnt_id ? din1 : din0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = (state == IDLE) ? ((req0 || req1) ? SERVE : IDLE) :
                 (state == SERVE) ? DONE : IDLE;
  end
  always_comb begin
    serve    = (state == SERVE);
    ram_we   = serve && sel_we;
    ram_addr = serve ? sel_addr : '0;
    ram_din  = serve ? sel_din : '0;
    ack0     = (state == DONE) && !gnt_id;
    ack1     = (state == DONE) && gnt_id;
    busy     = (state != IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt_id <= 1'b1;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) gnt_id <= winner;
      if (state == SERVE && !sel_we && !gnt_id) rdata0 <= ram_dout;
      if (state == SERVE && !sel_we && gnt_id) rdata1 <= ram_dout;
    end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_ram_rr_arbiter;
  localparam int AW = 2;
  localparam int DW = 3;
  logic clk = 1'b0;
  logic rst;
  logic req0, we0, ack0, req1, we1, ack1, ram_we, busy, gnt_id;
  logic [AW-1:0] addr0, addr1, ram_addr;
  logic [DW-1:0] din0, din1, rdata0, rdata1, ram_din, ram_dout;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mem [4] = '{default: '0};

  ram_rr_arbiter #(.addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .ack1(ack1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic set_cmd(input int r, input int rq, input int w, input int a, input int d);
    if (r == 0) begin req0 = rq[0]; we0 = w[0]; addr0 = AW'(a); din0 = DW'(d); end
    else begin req1 = rq[0]; we1 = w[0]; addr1 = AW'(a); din1 = DW'(d); end
  endtask

  // issues one command and returns the cycles until its ack (-1 on timeout), ending in the ack cycle
  task automatic access(input int r, input int w, input int a, input int d, output int lat);
    @(negedge clk);
    set_cmd(r, 1, w, a, d);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if ((r == 0 ? ack0 : ack1) === 1'b1) begin lat = i; break; end
    end
    set_cmd(r, 0, w, a, d);
  endtask

  task automatic pulse_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset;
    vectors++;
    if ({busy, ram_we, ack0, ack1, gnt_id, rdata0, rdata1} !== {5'b00001, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", {busy, ram_we, ack0, ack1, gnt_id, rdata0, rdata1}, {5'b00001, 6'd0});
    end
    @(negedge clk); set_cmd(0, 1, 1, 3, 6);
    @(negedge clk);
    vectors++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 2'd3, 3'd6}) begin
      miscompares++;
      $display("FAIL reset_pre_serve: got %b want %b", {ram_we, ram_addr, ram_din}, {1'b1, 2'd3, 3'd6});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ram_we, busy, ack0, ack1, gnt_id, rdata0, rdata1} !== {5'b00001, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_serve: got %b want %b", {ram_we, busy, ack0, ack1, gnt_id, rdata0, rdata1}, {5'b00001, 6'd0});
    end
    set_cmd(0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({mem[3], busy, ack0} !== {3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_discard_write: got mem=%0d busy=%b ack0=%b want mem=0 busy=0 ack0=0", mem[3], busy, ack0);
    end
  endtask

  task automatic test_write_read;
    @(negedge clk); set_cmd(0, 1, 1, 2, 5);
    @(negedge clk);
    vectors++;
    if ({busy, ram_we, ram_addr, ram_din, gnt_id, ack0} !== {1'b1, 1'b1, 2'd2, 3'd5, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL write_serve: got %b want %b", {busy, ram_we, ram_addr, ram_din, gnt_id, ack0}, {2'b11, 2'd2, 3'd5, 2'b00});
    end
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, ram_we, ram_addr} !== {3'b100, 2'd0}) begin
      miscompares++;
      $display("FAIL write_ack: got %b want %b", {ack0, ack1, ram_we, ram_addr}, 5'b10000);
    end
    set_cmd(0, 1, 0, 2, 0);
    @(negedge clk);
    vectors++;
    if ({busy, ack0, mem[2]} !== {2'b00, 3'd5}) begin
      miscompares++;
      $display("FAIL write_idle: got busy=%b ack0=%b mem2=%0d want 0 0 5", busy, ack0, mem[2]);
    end
    @(negedge clk);
    vectors++;
    if ({ram_we, ram_addr} !== {1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL read_serve: got %b want %b", {ram_we, ram_addr}, {1'b0, 2'd2});
    end
    @(negedge clk);
    vectors++;
    if ({ack0, rdata0, rdata1} !== {1'b1, 3'd5, 3'd0}) begin
      miscompares++;
      $display("FAIL read_ack: got ack0=%b rdata0=%0d rdata1=%0d want 1 5 0", ack0, rdata0, rdata1);
    end
    set_cmd(0, 0, 0, 0, 0);
  endtask

  task automatic test_tie;
    int cyc, prev, got;
    pulse_reset;
    @(negedge clk);
    set_cmd(0, 1, 1, 0, 1);
    set_cmd(1, 1, 1, 3, 4);
    cyc = 0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        cyc++;
        if (ack0 === 1'b1 || ack1 === 1'b1) begin got = (ack1 === 1'b1) ? 1 : 0; break; end
      end
      vectors++;
      if (got !== k % 2 || cyc - prev !== (k == 0 ? 2 : 3)) begin
        miscompares++;
        $display("FAIL tie_grant%0d: got id=%0d gap=%0d want id=%0d gap=%0d", k, got, cyc - prev, k % 2, k == 0 ? 2 : 3);
      end
      prev = cyc;
      if (got == 0) set_cmd(0, 1, 1, 0, 1);
      if (got == 1) set_cmd(1, 1, 1, 3, 4);
    end
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    vectors++;
    if ({mem[0], mem[3]} !== {3'd1, 3'd4}) begin
      miscompares++;
      $display("FAIL tie_mem: got %0d %0d want 1 4", mem[0], mem[3]);
    end
  endtask

  task automatic test_coherency;
    int lat;
    access(1, 0, 3, 0, lat);
    vectors++;
    if (lat !== 2 || rdata1 !== 3'd4) begin
      miscompares++;
      $display("FAIL coh_read1: got lat=%0d rdata1=%0d want 2 4", lat, rdata1);
    end
    access(1, 1, 1, 3, lat);
    access(0, 0, 1, 0, lat);
    vectors++;
    if (lat !== 2 || rdata0 !== 3'd3 || rdata1 !== 3'd4) begin
      miscompares++;
      $display("FAIL coh_read0: got lat=%0d rdata0=%0d rdata1=%0d want 2 3 4", lat, rdata0, rdata1);
    end
  endtask

  task automatic test_held_req;
    int cnt, last, bad;
    logic busy_after;
    @(negedge clk); set_cmd(0, 1, 0, 1, 0);
    cnt = 0; last = -1; bad = 0; busy_after = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) busy_after = busy;
      if (ack1 !== 1'b0) bad++;
      if (ack0 === 1'b1) begin
        if ((last < 0 && i != 2) || (last >= 0 && i - last != 3)) bad++;
        last = i;
        cnt++;
      end
    end
    set_cmd(0, 0, 0, 0, 0);
    vectors++;
    if (cnt !== 4 || bad !== 0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL held_req: got acks=%0d bad=%0d busy_after_ack=%b want 4 0 0", cnt, bad, busy_after);
    end
    vectors++;
    if (rdata0 !== 3'd3) begin
      miscompares++;
      $display("FAIL held_rdata: got %0d want 3", rdata0);
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, ram_we, ack0, ack1, gnt_id, ram_addr, ram_din} !== 10'd0) begin
        miscompares++;
        $display("FAIL idle%0d: got %b want %b", i, {busy, ram_we, ack0, ack1, gnt_id, ram_addr, ram_din}, 10'd0);
      end
    end
  endtask

  // model tracks accesses as: grant chosen, RAM touched one cycle later, acked the cycle after
  task automatic test_random;
    int lat, slot;
    int pend[2], cw[2], ca[2], cd[2];
    logic g;
    logic [DW-1:0] ref_mem[4];
    logic [DW-1:0] m_rd[2];
    logic e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    for (int a = 0; a < 4; a++) access(a % 2, 1, a, 7 - a, lat);
    pulse_reset;
    for (int a = 0; a < 4; a++) ref_mem[a] = DW'(7 - a);
    m_rd[0] = '0; m_rd[1] = '0;
    g = 1'b1; slot = 0;
    for (int r = 0; r < 2; r++) begin pend[r] = 0; cw[r] = 0; ca[r] = 0; cd[r] = 0; end
    for (int c = 0; c < 420; c++) begin
      e_we   = (slot == 1) ? cw[g][0] : 1'b0;
      e_addr = (slot == 1) ? AW'(ca[g]) : '0;
      e_din  = (slot == 1) ? DW'(cd[g]) : '0;
      vectors++;
      if ({busy, ram_we, ram_addr, ram_din, ack0, ack1, gnt_id, rdata0, rdata1} !==
          {slot != 0, e_we, e_addr, e_din, slot == 2 && !g, slot == 2 && g, g, m_rd[0], m_rd[1]}) begin
        miscompares++;
        $display("FAIL rand%0d: got %b want %b", c,
                 {busy, ram_we, ram_addr, ram_din, ack0, ack1, gnt_id, rdata0, rdata1},
                 {slot != 0, e_we, e_addr, e_din, slot == 2 && !g, slot == 2 && g, g, m_rd[0], m_rd[1]});
      end
      if (slot == 2) pend[g] = 0;
      for (int r = 0; r < 2; r++) begin
        if (pend[r] == 0 && c < 400 && $urandom_range(0, 3) != 0) begin
          pend[r] = 1;
          cw[r] = int'($urandom_range(0, 1));
          ca[r] = int'($urandom_range(0, 3));
          cd[r] = int'($urandom_range(0, 7));
        end
        set_cmd(r, pend[r], cw[r], ca[r], cd[r]);
      end
      @(posedge clk);
      if (slot == 0) begin
        if (pend[0] != 0 || pend[1] != 0) begin
          g = (pend[0] != 0 && pend[1] != 0) ? !g : (pend[1] != 0);
          slot = 1;
        end
      end else if (slot == 1) begin
        if (cw[g] != 0) ref_mem[ca[g]] = DW'(cd[g]);
        else m_rd[g] = ref_mem[ca[g]];
        slot = 2;
      end else slot = 0;
      @(negedge clk);
    end
    for (int a = 0; a < 4; a++) begin
      vectors++;
      if (mem[a] !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL rand_mem%0d: got %0d want %0d", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_write_read;
    test_tie;
    test_coherency;
    test_held_req;
    test_idle;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
